param_register_file: RTL and testbench
======================================

# param_register_file

Parametrised successor to the pipeline's architectural register file: 1 write port, 2 combinational read ports, configurable width and depth, optional hardwired-zero entry. Adds a post-reset/clear initialisation sweep, a per-entry pending-write scoreboard for the decode-stage hazard unit, and optional same-cycle write-to-read forwarding. Sits between decode (reads, issue) and writeback (writes) in the 5-stage pipeline.

## Interface
- DATA_WIDTH, 32, bits per entry
- ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH entries
- ZERO_REG, 1, entry 0 reads 0 and ignores writes and issues when 1
- INIT_INDEX, 1, sweep loads entry i with i (truncated to DATA_WIDTH) when 1, else 0

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- clearReq  in  1  start re-initialisation sweep (honoured only when ready=1)
- ready  out  1  1 = sweep finished, file usable
- writeEnable  in  1  writeback valid
- writeReg  in  ADDR_WIDTH  writeback destination
- writeData  in  DATA_WIDTH  writeback value
- readReg1, readReg2  in  ADDR_WIDTH  read addresses
- readData1, readData2  out  DATA_WIDTH  read values
- issueValid  in  1  decode issued an instruction writing issueReg
- issueReg  in  ADDR_WIDTH  destination being issued
- pending1, pending2  out  1  entry at readRegN has an outstanding write

## Operation
- FSM states INIT, RUN. Reset → INIT, sweep counter 0, all pending bits 0, ready 0.
- INIT: each cycle writes entry cnt with (INIT_INDEX ? cnt : 0), cnt++; on the edge writing entry DEPTH-1, go RUN. writeEnable, issueValid ignored; readData1/2 = 0, pending1/2 = 0.
- RUN: ready=1. clearReq → INIT next edge, counter 0, all pending bits cleared; writeEnable/issueValid on that edge are dropped.
- Write: entry writeReg ← writeData on edge when RUN && writeEnable && !(ZERO_REG && writeReg==0).
- Read: readDataN = registers[readRegN]; forced 0 when ZERO_REG && readRegN==0.
- Scoreboard: pending[issueReg] set on edge when RUN && issueValid (not entry 0 if ZERO_REG); pending[writeReg] cleared on accepted write. Same edge, same entry, issue and write: set wins (newer producer in flight). Different entries: both take effect.
- pendingN = pending[readRegN] combinational, forced 0 for entry 0 when ZERO_REG.
- Array contents are not reset by rst_n; the sweep defines them.

## Timing
- Reads and pendingN: combinational, 0-cycle latency.
- Write visible on read ports the cycle after the edge (see Configuration).
- ready rises DEPTH edges after rst_n deasserts (first edge writes entry 0); DEPTH+1 edges after an accepted clearReq.
- Issue visible on pendingN the cycle after the issue edge.
- rst_n assertion mid-sweep or mid-run: immediately ready=0, pending=0, readData=0, state INIT; sweep restarts from 0 after release.
- clearReq during INIT: ignored, sweep continues unchanged.
- Reset values: ready 0, pending1/2 0, readData1/2 0.

## Configuration
- REGFILE_BYPASS_EN defined: when an accepted write targets readRegN in the same cycle, readDataN = writeData and pendingN = 0 combinationally (ZERO_REG entry still reads 0).
- Not defined: readDataN shows the old value and pendingN stays at the stored bit until the write edge; no writeData→readData combinational path.

## Test plan
- Reset release, defaults → ready 0 for 32 edges, 1 after; readReg1=5, readReg2=31 → 5, 31; readReg1=0 → 0.
- RUN, write reg 7 = 0xDEADBEEF → next cycle readData1=0xDEADBEEF; write reg 0 = 0x1234 → reg 0 still reads 0.
- Issue reg 9, later write reg 9 → pending1 (readReg1=9) 1 from cycle after issue until cycle after write; issue+write reg 9 same edge → pending stays 1.
- Same-cycle write reg 3 = 0xA5A5A5A5 with readReg2=3 → with REGFILE_BYPASS_EN readData2=0xA5A5A5A5, pending2=0 that cycle; without, readData2=3 that cycle, 0xA5A5A5A5 next.
- Write reg 4 = 0x55, pend reg 6, then clearReq → ready 0 for 32 cycles, pending all 0, then reg 4 reads 4; rst_n pulsed at sweep cycle 10 → readData 0 immediately, ready after 32 edges from release.
- INIT_INDEX=0, ZERO_REG=0, DATA_WIDTH=8, ADDR_WIDTH=3 → ready after 8 edges, all entries read 0; write entry 0 = 0xFF → reads 0xFF.

Source files
------------

// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
//
// Parametrised architectural register file for the 5-stage pipeline. It has
// one write port (writeback), two combinational read ports (decode), an
// optional hardwired-zero entry 0, and an initialisation sweep after reset or
// on clearReq. It also keeps a per-entry pending-write scoreboard for the
// decode-stage hazard unit.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a write accepted in the current cycle is forwarded
//   combinationally to a read port with the same address. That read port then
//   shows writeData, and its pending bit reads 0.
//   When not defined, the read ports show the stored contents until the write
//   edge, and there is no writeData -> readData path.
//
// Parameters
//   DATA_WIDTH : bits per entry
//   ADDR_WIDTH : address bits, DEPTH = 2**ADDR_WIDTH
//   ZERO_REG   : 1 -> entry 0 reads 0 and ignores writes and issues
//   INIT_INDEX : 1 -> sweep loads entry i with i (truncated), else 0
//
// Ports
//   clk, rst_n            : clock (rising edge); asynchronous active-low reset
//   clearReq              : restart the sweep (honoured only while ready=1)
//   ready                 : 1 once the sweep has finished
//   writeEnable/Reg/Data  : writeback port
//   readReg1/2, readData1/2 : combinational read ports
//   issueValid, issueReg  : decode issued an instruction writing issueReg
//   pending1/2            : entry at readRegN has an outstanding write
// -----------------------------------------------------------------------------
module param_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int INIT_INDEX = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clearReq,
  output logic                  ready,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  input  logic                  issueValid,
  input  logic [ADDR_WIDTH-1:0] issueReg,
  output logic                  pending1,
  output logic                  pending2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic [DEPTH-1:0]        pending_q, pending_d;

  // Storage has no reset; the sweep defines every entry before use.
  logic [DATA_WIDTH-1:0]   regs [DEPTH];

  logic                    run;
  logic                    write_acc;
  logic                    issue_acc;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_data;

  assign run = (state_q == ST_RUN);

  // A clearReq edge drops any write or issue that arrives with it.
  assign write_acc = run && !clearReq && writeEnable &&
                     !((ZERO_REG != 0) && (writeReg == '0));
  assign issue_acc = run && !clearReq && issueValid &&
                     !((ZERO_REG != 0) && (issueReg == '0));

  // ---------------------------------------------------------------------------
  // Control FSM: INIT sweeps cnt through every entry, then RUN.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (clearReq) begin
          state_d = ST_INIT;
          ready_d = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        ready_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // Scoreboard next state. The set is applied after the clear, so an issue and
  // a write to the same entry on one edge leave the bit set: the newer
  // producer is still in flight.
  always_comb begin
    pending_d = pending_q;
    if (!run || clearReq) begin
      pending_d = '0;
    end else begin
      if (write_acc) pending_d[writeReg] = 1'b0;
      if (issue_acc) pending_d[issueReg] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      pending_q <= pending_d;
    end
  end

  assign ready = ready_q;

  // ---------------------------------------------------------------------------
  // Storage write port: the sweep owns it during INIT, writeback during RUN.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = writeReg;
    mem_data = writeData;
    if (state_q == ST_INIT) begin
      mem_we   = 1'b1;
      mem_addr = cnt_q;
      mem_data = (INIT_INDEX != 0) ? DATA_WIDTH'(cnt_q) : '0;
    end else if (write_acc) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) regs[mem_addr] <= mem_data;
  end

  // ---------------------------------------------------------------------------
  // Read ports, built identically for both addresses.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] rd_addr [2];
  logic [DATA_WIDTH-1:0] rd_data [2];
  logic                  rd_pend [2];

  assign rd_addr[0] = readReg1;
  assign rd_addr[1] = readReg2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic rd_zero;
    assign rd_zero = (ZERO_REG != 0) && (rd_addr[gi] == '0);
`ifdef REGFILE_BYPASS_EN
    logic rd_byp;
    // write_acc already excludes entry 0 when it is hardwired to zero.
    assign rd_byp = write_acc && (writeReg == rd_addr[gi]);
    assign rd_data[gi] = (!run || rd_zero) ? '0 :
                         rd_byp ? writeData : regs[rd_addr[gi]];
    assign rd_pend[gi] = (!run || rd_zero || rd_byp) ? 1'b0 :
                         pending_q[rd_addr[gi]];
`else
    assign rd_data[gi] = (!run || rd_zero) ? '0 : regs[rd_addr[gi]];
    assign rd_pend[gi] = (!run || rd_zero) ? 1'b0 : pending_q[rd_addr[gi]];
`endif
  end

  assign readData1 = rd_data[0];
  assign readData2 = rd_data[1];
  assign pending1  = rd_pend[0];
  assign pending2  = rd_pend[1];

endmodule

// File: tb/tb_param_register_file.sv
// -----------------------------------------------------------------------------
// tb_param_register_file
//
// Drives two instances side by side:
//   A: default parameters (32x32, zero register, index init)
//   B: DATA_WIDTH=8, ADDR_WIDTH=3, ZERO_REG=0, INIT_INDEX=0
//
// The stimulus process sets the inputs just after each rising edge. It asks a
// behavioural model for the outputs expected in that cycle, pushes them into a
// per-instance queue, and then advances the model across the edge. A monitor
// on the falling edge pops each queue and compares the popped values against
// the outputs of the matching instance. A handful of directed checks against
// literal values from the test plan complement the scoreboard.
// -----------------------------------------------------------------------------
module tb_param_register_file;

  typedef struct packed {
    logic        rdy;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        p1;
    logic        p2;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Generic per-instance stimulus (index 0 = A, 1 = B).
  logic        clr_v [2];
  logic        we_v  [2];
  logic        iv_v  [2];
  logic [31:0] wr_v  [2];
  logic [31:0] wd_v  [2];
  logic [31:0] r1_v  [2];
  logic [31:0] r2_v  [2];
  logic [31:0] ir_v  [2];

  // Instance A wiring
  logic        a_ready, a_p1, a_p2;
  logic [31:0] a_rd1, a_rd2;
  logic        a_clr, a_we, a_iv;
  logic [4:0]  a_wr, a_r1, a_r2, a_ir;
  logic [31:0] a_wd;
  assign a_clr = clr_v[0];
  assign a_we  = we_v[0];
  assign a_iv  = iv_v[0];
  assign a_wr  = wr_v[0][4:0];
  assign a_r1  = r1_v[0][4:0];
  assign a_r2  = r2_v[0][4:0];
  assign a_ir  = ir_v[0][4:0];
  assign a_wd  = wd_v[0];

  // Instance B wiring
  logic        b_ready, b_p1, b_p2;
  logic [7:0]  b_rd1, b_rd2;
  logic        b_clr, b_we, b_iv;
  logic [2:0]  b_wr, b_r1, b_r2, b_ir;
  logic [7:0]  b_wd;
  assign b_clr = clr_v[1];
  assign b_we  = we_v[1];
  assign b_iv  = iv_v[1];
  assign b_wr  = wr_v[1][2:0];
  assign b_r1  = r1_v[1][2:0];
  assign b_r2  = r2_v[1][2:0];
  assign b_ir  = ir_v[1][2:0];
  assign b_wd  = wd_v[1][7:0];

  param_register_file dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .clearReq   (a_clr),
    .ready      (a_ready),
    .writeEnable(a_we),
    .writeReg   (a_wr),
    .writeData  (a_wd),
    .readReg1   (a_r1),
    .readReg2   (a_r2),
    .readData1  (a_rd1),
    .readData2  (a_rd2),
    .issueValid (a_iv),
    .issueReg   (a_ir),
    .pending1   (a_p1),
    .pending2   (a_p2)
  );

  param_register_file #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3),
    .ZERO_REG  (0),
    .INIT_INDEX(0)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .clearReq   (b_clr),
    .ready      (b_ready),
    .writeEnable(b_we),
    .writeReg   (b_wr),
    .writeData  (b_wd),
    .readReg1   (b_r1),
    .readReg2   (b_r2),
    .readData1  (b_rd1),
    .readData2  (b_rd2),
    .issueValid (b_iv),
    .issueReg   (b_ir),
    .pending1   (b_p1),
    .pending2   (b_p2)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int          depth_c [2] = '{32, 8};
  bit          zr_c    [2] = '{1'b1, 1'b0};
  bit          ii_c    [2] = '{1'b1, 1'b0};
  logic [31:0] mask_c  [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};

  logic [31:0] mem_m  [2][32];
  bit          pend_m [2][32];
  bit          run_m  [2];
  int          idx_m  [2];

  obs_t qa[$];
  obs_t qb[$];

  int checks   = 0;
  int failures = 0;

  function automatic void model_reset(int k);
    run_m[k] = 1'b0;
    idx_m[k] = 0;
    for (int i = 0; i < 32; i++) pend_m[k][i] = 1'b0;
  endfunction

  function automatic bit accepted(int k);
    return run_m[k] && we_v[k] && !clr_v[k] && !(zr_c[k] && wr_v[k] == 0);
  endfunction

  function automatic logic [31:0] read_m(int k, logic [31:0] a);
    if (zr_c[k] && a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (accepted(k) && wr_v[k] == a) return wd_v[k] & mask_c[k];
`endif
    return mem_m[k][a];
  endfunction

  function automatic bit pend_f(int k, logic [31:0] a);
    if (zr_c[k] && a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (accepted(k) && wr_v[k] == a) return 1'b0;
`endif
    return pend_m[k][a];
  endfunction

  function automatic obs_t model_out(int k);
    obs_t o;
    o = '0;
    if (rst_n !== 1'b1 || !run_m[k]) return o;
    o.rdy = 1'b1;
    o.d1  = read_m(k, r1_v[k]);
    o.d2  = read_m(k, r2_v[k]);
    o.p1  = pend_f(k, r1_v[k]);
    o.p2  = pend_f(k, r2_v[k]);
    return o;
  endfunction

  function automatic void model_edge(int k);
    bit acc;
    acc = accepted(k);
    if (!run_m[k]) begin
      mem_m[k][idx_m[k]] = ii_c[k] ? (32'(idx_m[k]) & mask_c[k]) : 32'h0;
      idx_m[k]++;
      if (idx_m[k] == depth_c[k]) run_m[k] = 1'b1;
    end else if (clr_v[k]) begin
      model_reset(k);
    end else begin
      if (acc) begin
        mem_m[k][wr_v[k]]  = wd_v[k] & mask_c[k];
        pend_m[k][wr_v[k]] = 1'b0;
      end
      if (iv_v[k] && !(zr_c[k] && ir_v[k] == 0)) pend_m[k][ir_v[k]] = 1'b1;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helpers and monitor
  // ---------------------------------------------------------------------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic cmp_obs(string who, obs_t e, obs_t a);
    chk({who, ".ready"},    32'(a.rdy), 32'(e.rdy));
    chk({who, ".readData1"}, a.d1,      e.d1);
    chk({who, ".readData2"}, a.d2,      e.d2);
    chk({who, ".pending1"}, 32'(a.p1),  32'(e.p1));
    chk({who, ".pending2"}, 32'(a.p2),  32'(e.p2));
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      a = '{a_ready, a_rd1, a_rd2, a_p1, a_p2};
      cmp_obs("A", e, a);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      a = '{b_ready, {24'h0, b_rd1}, {24'h0, b_rd2}, b_p1, b_p2};
      cmp_obs("B", e, a);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // One clock cycle: publish the expected outputs, cross the edge, advance.
  task automatic cyc();
    if (rst_n !== 1'b1) begin
      model_reset(0);
      model_reset(1);
    end
    qa.push_back(model_out(0));
    qb.push_back(model_out(1));
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst_n === 1'b1) model_edge(k);
      else model_reset(k);
    end
    #1;
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      clr_v[k] = 1'b0;
      we_v[k]  = 1'b0;
      iv_v[k]  = 1'b0;
    end
  endtask

  // Runs cycles until A is ready and reports how many edges each instance took.
  task automatic wait_ready(string tag, int exp_a, int exp_b);
    int n, nb;
    n  = 0;
    nb = 0;
    do begin
      cyc();
      n++;
      if (b_ready && nb == 0) nb = n;
      idle();
    end while (!a_ready && n < 100);
    chk({tag, ".A_ready_edges"}, 32'(n), 32'(exp_a));
    chk({tag, ".B_ready_edges"}, 32'(nb), 32'(exp_b));
  endtask

  initial begin
    int ncyc;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      clr_v[k] = 0; we_v[k] = 0; iv_v[k] = 0;
      wr_v[k] = 0; wd_v[k] = 0; r1_v[k] = 0; r2_v[k] = 0; ir_v[k] = 0;
    end
    @(posedge clk); #1;
    repeat (3) cyc();

    $display("STEP reset release and initial sweep");
    rst_n = 1'b1;
    r1_v[0] = 5; r2_v[0] = 31; r1_v[1] = 0; r2_v[1] = 7;
    wait_ready("sweep", 32, 8);
    chk("A.read_reg5", a_rd1, 32'd5);
    chk("A.read_reg31", a_rd2, 32'd31);
    chk("B.read_init0", {24'h0, b_rd2}, 32'd0);
    r1_v[0] = 0;
    cyc();
    chk("A.read_reg0", a_rd1, 32'd0);

    $display("STEP write reg 7 (A) and entry 0 (B)");
    we_v[0] = 1; wr_v[0] = 7; wd_v[0] = 32'hDEAD_BEEF; r1_v[0] = 7;
    we_v[1] = 1; wr_v[1] = 0; wd_v[1] = 32'hFF; r1_v[1] = 0;
    cyc(); idle(); cyc();
    chk("A.write_reg7", a_rd1, 32'hDEAD_BEEF);
    chk("B.write_entry0", {24'h0, b_rd1}, 32'hFF);

    $display("STEP write to hardwired zero entry");
    we_v[0] = 1; wr_v[0] = 0; wd_v[0] = 32'h1234; r1_v[0] = 0;
    cyc(); idle(); cyc();
    chk("A.zero_after_write", a_rd1, 32'd0);

    $display("STEP pending scoreboard on reg 9");
    iv_v[0] = 1; ir_v[0] = 9; r1_v[0] = 9;
    cyc(); idle(); repeat (3) cyc();
    chk("A.pending_after_issue", 32'(a_p1), 32'd1);
    we_v[0] = 1; wr_v[0] = 9; wd_v[0] = 32'h0000_0909;
    cyc(); idle(); cyc();
    chk("A.pending_after_write", 32'(a_p1), 32'd0);
    iv_v[0] = 1; ir_v[0] = 9; we_v[0] = 1; wr_v[0] = 9; wd_v[0] = 32'h0000_0A0A;
    cyc(); idle(); cyc();
    chk("A.pending_issue_wins", 32'(a_p1), 32'd1);
    we_v[0] = 1; wr_v[0] = 9; wd_v[0] = 32'h0000_0B0B;
    cyc(); idle(); cyc();

    $display("STEP same-cycle write/read reg 3");
    we_v[0] = 1; wr_v[0] = 3; wd_v[0] = 32'hA5A5_A5A5; r2_v[0] = 3;
    cyc(); idle(); cyc();
    chk("A.write_reg3_next", a_rd2, 32'hA5A5_A5A5);

    $display("STEP clearReq re-initialisation");
    we_v[0] = 1; wr_v[0] = 4; wd_v[0] = 32'h55;
    cyc(); idle();
    iv_v[0] = 1; ir_v[0] = 6;
    cyc(); idle();
    r1_v[0] = 4; r2_v[0] = 6;
    clr_v[0] = 1; clr_v[1] = 1;
    wait_ready("clear", 33, 9);
    chk("A.reg4_reinit", a_rd1, 32'd4);
    chk("A.pend6_cleared", 32'(a_p2), 32'd0);

    $display("STEP reset pulse mid-sweep");
    clr_v[0] = 1; clr_v[1] = 1;
    cyc(); idle();
    repeat (10) cyc();
    rst_n = 1'b0;
    #1;
    chk("A.readData_in_reset", a_rd1, 32'd0);
    cyc();
    rst_n = 1'b1;
    wait_ready("rst_mid", 32, 8);

    $display("STEP randomized traffic");
    for (int t = 0; t < 800; t++) begin
      for (int k = 0; k < 2; k++) begin
        clr_v[k] = ($urandom_range(0, 99) == 0);
        we_v[k]  = $urandom_range(0, 1);
        iv_v[k]  = ($urandom_range(0, 9) < 3);
        wr_v[k]  = $urandom_range(0, depth_c[k] - 1);
        wd_v[k]  = $urandom;
        ir_v[k]  = ($urandom_range(0, 3) == 0) ? wr_v[k] : $urandom_range(0, depth_c[k] - 1);
        r1_v[k]  = ($urandom_range(0, 3) == 0) ? wr_v[k] : $urandom_range(0, depth_c[k] - 1);
        r2_v[k]  = ($urandom_range(0, 3) == 0) ? ir_v[k] : $urandom_range(0, depth_c[k] - 1);
      end
      cyc();
    end
    idle();
    cyc();
    @(negedge clk);
    #1;
    ncyc = qa.size() + qb.size();
    chk("scoreboard_drained", 32'(ncyc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
